// File: rtl/frame_block_streamer.sv
// Frame store plus block-ordered streamer: loads NUM_FRAMES square frames, then on request streams
// one frame block by block as signed (pixel - 128) * (QP + 1) over a valid/ready port.
module frame_block_streamer #(
   parameter int NUM_FRAMES = 16,
   parameter int FRAME_DIM  = 32,
   parameter int BLK_DIM    = 16,
   parameter int DATA_W     = 8,
   parameter int QP_W       = 5,
   parameter int OUT_W      = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid_data,
   input  logic [DATA_W-1:0]             data,
   input  logic                          in_valid_param,
   input  logic [$clog2(NUM_FRAMES)-1:0] index,
   input  logic                          mode,
   input  logic [QP_W-1:0]               QP,
   input  logic                          out_ready,
   output logic                          out_valid,
   output logic [OUT_W-1:0]              out_value,
   output logic                          busy
);

   localparam int IDX_W   = $clog2(NUM_FRAMES);
   localparam int FPIX    = FRAME_DIM * FRAME_DIM;
   localparam int PIX_W   = $clog2(FPIX);
   localparam int ADDR_W  = IDX_W + PIX_W;
   localparam int BPR     = FRAME_DIM / BLK_DIM;
   localparam int NB      = BPR * BPR;
   localparam int NB_W    = (NB > 1) ? $clog2(NB) : 1;
   localparam int BLK_PIX = BLK_DIM * BLK_DIM;
   localparam int PROD_W  = DATA_W + QP_W + 3;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_READY, S_PARAM, S_STREAM} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   load_cnt_q;
   logic                loaded_q;
   logic [IDX_W-1:0]    index_q;
   logic [QP_W-1:0]     qp_q;
   logic [NB-1:0]       modes_q;
   logic [NB_W-1:0]     param_cnt_q;
   logic [PIX_W:0]      issue_cnt_q;
   logic [PIX_W:0]      acc_cnt_q;
   logic                s1_valid_q;
   logic [DATA_W-1:0]   rd_data_q;
   logic                out_valid_q;
   logic [OUT_W-1:0]    out_value_q;
   logic [DATA_W-1:0]   mem_q [NUM_FRAMES*FPIX];

   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic                param_start;
   logic                stall;
   logic                issue;
   logic                accept;
   logic                last_beat;
   logic [NB_W-1:0]     blk_idx;
   logic [PIX_W-1:0]    rd_pix;
   logic [ADDR_W-1:0]   rd_addr;
   logic signed [DATA_W:0]   pix_s;
   logic signed [QP_W+1:0]   scale_s;
   logic signed [PROD_W-1:0] prod_s;
   logic [OUT_W-1:0]    out_d;

   assign wr_en       = in_valid_data && (state_q inside {S_IDLE, S_LOAD, S_READY});
   assign wr_addr     = (state_q == S_LOAD) ? load_cnt_q : '0;
   assign param_start = (state_q == S_READY) && in_valid_param && loaded_q && !in_valid_data;
   // A stalled output freezes the whole read/multiply pipeline.
   assign stall       = out_valid_q && !out_ready;
   assign issue       = (state_q == S_STREAM) && !issue_cnt_q[PIX_W] && !stall;
   assign accept      = out_valid_q && out_ready;
   assign last_beat   = accept && (acc_cnt_q == (PIX_W+1)'(FPIX - 1));
   assign rd_addr     = {index_q, rd_pix};

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential blocks use non-blocking assignments so every register samples pre-edge values.
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      // NOTE: default first, so no path through the case leaves state_d unassigned and infers a latch.
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (in_valid_data) state_d = S_LOAD;
         S_LOAD:   if (in_valid_data && (&load_cnt_q)) state_d = S_READY;
         S_READY: begin
            if (in_valid_data)    state_d = S_LOAD;
            else if (param_start) state_d = (NB > 1) ? S_PARAM : S_STREAM;
         end
         S_PARAM:  if (!in_valid_param || param_cnt_q == NB_W'(NB - 1)) state_d = S_STREAM;
         S_STREAM: if (last_beat) state_d = S_READY;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = state_q inside {S_LOAD, S_PARAM, S_STREAM};
   end

   assign out_valid = out_valid_q;
   assign out_value = out_value_q;

   // Beat number -> raster position inside the selected frame, honouring the block's scan mode.
   always_comb begin
      int unsigned beat, blk, off, row, col;
      beat    = 32'(issue_cnt_q[PIX_W-1:0]);
      blk     = beat / BLK_PIX;
      off     = beat % BLK_PIX;
      blk_idx = NB_W'(blk);
      if (modes_q[blk_idx]) begin
         row = off % BLK_DIM;
         col = off / BLK_DIM;
      end else begin
         row = off / BLK_DIM;
         col = off % BLK_DIM;
      end
      rd_pix = PIX_W'(((blk / BPR) * BLK_DIM + row) * FRAME_DIM + (blk % BPR) * BLK_DIM + col);
   end

   always_comb begin
      pix_s   = $signed({1'b0, rd_data_q}) - $signed({2'b01, {(DATA_W-1){1'b0}}});
      scale_s = $signed({2'b00, qp_q}) + $signed({{(QP_W+1){1'b0}}, 1'b1});
      prod_s  = PROD_W'(pix_s) * PROD_W'(scale_s);
      out_d   = OUT_W'(prod_s);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load_cnt_q  <= '0;
         loaded_q    <= 1'b0;
         index_q     <= '0;
         qp_q        <= '0;
         modes_q     <= '0;
         param_cnt_q <= '0;
         issue_cnt_q <= '0;
         acc_cnt_q   <= '0;
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_value_q <= '0;
      end else begin
         if (in_valid_data && (state_q inside {S_IDLE, S_READY})) begin
            load_cnt_q <= ADDR_W'(1);
            loaded_q   <= 1'b0;
         end else if (in_valid_data && state_q == S_LOAD) begin
            load_cnt_q <= load_cnt_q + ADDR_W'(1);
            if (&load_cnt_q) loaded_q <= 1'b1;
         end

         if (param_start) begin
            index_q     <= index;
            qp_q        <= QP;
            modes_q     <= '0;
            modes_q[0]  <= mode;
            param_cnt_q <= NB_W'(1);
         end else if (state_q == S_PARAM && in_valid_param) begin
            modes_q[param_cnt_q] <= mode;
            param_cnt_q          <= param_cnt_q + NB_W'(1);
         end

         if (state_q == S_READY) begin
            issue_cnt_q <= '0;
            acc_cnt_q   <= '0;
         end else begin
            if (issue)  issue_cnt_q <= issue_cnt_q + (PIX_W+1)'(1);
            if (accept) acc_cnt_q   <= acc_cnt_q + (PIX_W+1)'(1);
         end

         if (!stall) begin
            s1_valid_q  <= issue;
            out_valid_q <= s1_valid_q;
            out_value_q <= s1_valid_q ? out_d : '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: the store is deliberately not reset; its contents only mean something after a full load.
      if (wr_en) mem_q[wr_addr] <= data;
      if (issue) rd_data_q <= mem_q[rd_addr];
   end

endmodule

// File: doc/frame_block_streamer.md
# frame_block_streamer

Parametrised frame store and block-ordered output streamer for the pixel-processing datapath. It loads NUM_FRAMES square frames of 8-bit pixels over a serial data port. On a parameter request, it selects one frame, a QP and per-block scan modes. It then streams that frame block by block as signed, QP-scaled values over a valid/ready output port. It generalises the fixed 16×32×32, four-mode, no-backpressure front end to arbitrary frame count, frame size and block size, and adds output backpressure.

## Interface
- NUM_FRAMES, 16, frames held in the store (power of 2, ≥2)
- FRAME_DIM, 32, frame side in pixels (power of 2)
- BLK_DIM, 16, block side in pixels (power of 2, divides FRAME_DIM); NB = (FRAME_DIM/BLK_DIM)^2 blocks per frame, equal to the mode-bit count
- DATA_W, 8, pixel width
- QP_W, 5, QP width
- OUT_W, 32, output width
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid_data  in  1  pixel strobe
- data  in  DATA_W  pixel, unsigned
- in_valid_param  in  1  parameter strobe, held NB consecutive cycles
- index  in  clog2(NUM_FRAMES)  frame select, sampled on the first param cycle only
- mode  in  1  scan mode of block k, sampled on param cycle k (k = 0..NB-1)
- QP  in  QP_W  scale, sampled on the first param cycle only
- out_ready  in  1  sink accepts out_value
- out_valid  out  1  out_value valid
- out_value  out  OUT_W  signed result
- busy  out  1  high while loading an incomplete burst or serving a request

## Operation
- States: IDLE (nothing loaded), LOAD, READY (store full), PARAM, STREAM.
- LOAD: pixel k of the burst (k = 0..NUM_FRAMES·FRAME_DIM²−1) is written to frame k/FRAME_DIM², raster position k mod FRAME_DIM².
  - in_valid_data may drop mid-burst; the address counter holds.
  - After the final pixel, go to READY and set the loaded flag.
- in_valid_data in READY starts a reload at address 0 and clears the loaded flag.
- in_valid_data in PARAM or STREAM is ignored.
- in_valid_param in READY captures index, QP and mode[0], then enters PARAM.
  - PARAM captures mode[1..NB-1] on the next NB−1 cycles, then enters STREAM.
  - in_valid_param dropping early in PARAM: missing modes read as 0 and STREAM starts on the drop.
- in_valid_param in IDLE, LOAD or STREAM is ignored; no output is produced.
- STREAM order: blocks in raster order b = 0..NB−1.
  - Within block b: mode[b]=0 gives row-major order, mode[b]=1 gives column-major (transposed) order.
  - Exactly FRAME_DIM² beats are produced.
- out_value = (pixel − 128) × (QP + 1), computed signed and sign-extended to OUT_W. Range is −128·2^QP_W … 127·2^QP_W.
- After the last beat is accepted, return to READY. Frames persist, so further requests need no reload.

## Timing
- Reset (async assert, sync release): out_valid=0, out_value=0, busy=0, state IDLE, loaded flag cleared. Store contents are not reset and are treated as invalid.
- Reset mid-LOAD or mid-STREAM aborts immediately; outputs go to 0 in the same cycle.
- out_value must be 0 whenever out_valid=0.
- Latency: first out_valid rises on the 2nd rising edge after the edge that sampled the last param cycle. This allows one cycle for the synchronous store read and one for the multiply register.
- Handshake: a beat transfers on a rising edge with out_valid && out_ready.
  - While out_valid && !out_ready, out_value holds stable and the read address does not advance.
  - Sustained out_ready=1 gives one beat per cycle with no bubbles.
- out_valid never rises while in_valid_data or in_valid_param is high in the same cycle.
- busy rises on the first sampled pixel or param cycle. It falls on the edge that completes the load or that accepts the last beat.

## Test plan
- Reset: assert rst mid-STREAM, asynchronously between edges → out_valid=0, out_value=0, busy=0 before the next edge. A subsequent param request is ignored until a full reload.
- Ramp load (pixel = k mod 256, defaults), param index 0, modes 0000, QP 0 → 1024 beats.
  - Beats 0,1 = −128, −127.
  - Beat 16 = frame pixel 32 → −96.
  - Beat 256 begins block 1 = pixel 16 → −112.
- Same load, index 15, modes 0100, QP 31.
  - Block 1 streams column-major: beats 256, 257 = pixels 16 and 48 → −3584, −2560.
  - Pixel value 255 → 4064.
- out_ready random toggling at 50% → every beat matches the ramp golden, out_value stable while stalled, exactly 1024 accepted beats.
- in_valid_param mid-LOAD and mid-STREAM → no new output. The stream in progress is unaffected and ends at exactly 1024 beats.
- Reparametrised build (NUM_FRAMES=4, FRAME_DIM=16, BLK_DIM=4, NB=16 modes), alternating modes, back-to-back requests on frames 0..3 → per-block orders and values match golden, no reload between requests.
